clint_irq: RTL and testbench

- Core-local interrupt source block. Generates the machine-mode pending bits (msip, mtip, meip) that feed the MIP CSR and the trap/interrupt decision logic.
- Contains:
  - a 64-bit free-running mtime counter with prescaler;
  - a 64-bit mtimecmp comparator;
  - a software-interrupt register;
  - an external-interrupt input stage.
- Registers are memory-mapped on a simple req/ack slave port reached from the MEM stage.

---
 rtl/clint_irq.sv | 234 +++++++++++++++++++++++
 tb/tb_clint_irq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_irq.sv
// clint_irq: core-local interrupt source block.
// Provides the machine-mode pending bits msip, mtip and meip.
// It contains a prescaled 64-bit mtime counter, a 64-bit mtimecmp comparator,
// a software-interrupt register and an external-interrupt input stage.
// Registers are reached through a req/ack slave port.
// Register map (byte offsets; addr[1:0] are ignored):
//   0x0000 MSIP         bit0 r/w, other bits read as 0
//   0x4000 MTIMECMP_LO  0x4004 MTIMECMP_HI
//   0xBFF8 MTIME_LO     0xBFFC MTIME_HI (read returns the hi half captured by the last MTIME_LO read)
// Optional feature: define CLINT_EXT_SYNC_EN to pass ext_irq_in through a 2-flop
// synchronizer, which gives 2 cycles of meip latency. Without it the input is
// registered once, which gives 1 cycle of latency.
module clint_irq #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    input  logic              ext_irq_in,
    output logic              msip,
    output logic              mtip,
    output logic              meip
);

    // Prescaler terminal count; TICK_DIV fits in 16 bits by construction.
    localparam logic [15:0] PS_MAX = 16'(TICK_DIV - 1);

    // Word-aligned register offsets, zero-extended to the port width.
    localparam logic [ADDR_W-1:0] OFF_MSIP     = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] OFF_MTCMP_LO = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] OFF_MTCMP_HI = ADDR_W'(16'h4004);
    localparam logic [ADDR_W-1:0] OFF_MTIME_LO = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] OFF_MTIME_HI = ADDR_W'(16'hBFFC);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_xfer;
    logic          w_wr;
    logic          w_rd;

    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic [15:0]   r_prescale;
    logic [31:0]   r_shadow_hi;
    logic          r_msip;
    logic          r_mtip;
    logic [31:0]   r_rdata;
    logic [31:0]   w_rdata_next;

    logic [ADDR_W-1:0] w_word;
    logic          w_sel_msip;
    logic          w_sel_cmp_lo;
    logic          w_sel_cmp_hi;
    logic          w_sel_mt_lo;
    logic          w_sel_mt_hi;
    logic          w_mtime_wr;

    // The byte-lane bits carry no information for word registers.
    logic          w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^addr[1:0];

    assign w_word       = {addr[ADDR_W-1:2], 2'b00};
    assign w_sel_msip   = (w_word == OFF_MSIP);
    assign w_sel_cmp_lo = (w_word == OFF_MTCMP_LO);
    assign w_sel_cmp_hi = (w_word == OFF_MTCMP_HI);
    assign w_sel_mt_lo  = (w_word == OFF_MTIME_LO);
    assign w_sel_mt_hi  = (w_word == OFF_MTIME_HI);

    assign w_wr       = w_xfer & we;
    assign w_rd       = w_xfer & ~we;
    assign w_mtime_wr = w_wr & (w_sel_mt_lo | w_sel_mt_hi);

    // Handshake state register: IDLE accepts a request and ACK always returns to IDLE.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a transfer is accepted only in IDLE, so req is ignored in ACK.
    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_xfer       = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Read-data mux; it stays zero unless a read is being accepted this cycle.
    always_comb begin
        w_rdata_next = 32'd0;
        if (w_rd) begin
            if (w_sel_msip) begin
                w_rdata_next = {31'd0, r_msip};
            end else if (w_sel_cmp_lo) begin
                w_rdata_next = r_mtimecmp[31:0];
            end else if (w_sel_cmp_hi) begin
                w_rdata_next = r_mtimecmp[63:32];
            end else if (w_sel_mt_lo) begin
                w_rdata_next = r_mtime[31:0];
            end else if (w_sel_mt_hi) begin
                w_rdata_next = r_shadow_hi;
            end
        end
    end

    // Read data is launched on the edge that raises ack and cleared on the next one.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_rdata <= 32'd0;
        end else begin
            r_rdata <= w_rdata_next;
        end
    end

    // Prescaler and mtime. A bus write replaces one half with no carry and restarts the prescaler.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_prescale <= 16'd0;
            r_mtime    <= 64'd0;
        end else if (w_mtime_wr) begin
            r_prescale <= 16'd0;
            if (w_sel_mt_lo) begin
                r_mtime[31:0]  <= wdata;
            end else begin
                r_mtime[63:32] <= wdata;
            end
        end else if (r_prescale == PS_MAX) begin
            r_prescale <= 16'd0;
            r_mtime    <= r_mtime + 64'd1;
        end else begin
            r_prescale <= r_prescale + 16'd1;
        end
    end

    // Capture the upper half on an MTIME_LO read so that a following MTIME_HI read is coherent.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_shadow_hi <= 32'd0;
        end else if (w_rd && w_sel_mt_lo) begin
            r_shadow_hi <= r_mtime[63:32];
        end
    end

    // mtimecmp halves are written independently.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_wr && w_sel_cmp_lo) begin
            r_mtimecmp[31:0] <= wdata;
        end else if (w_wr && w_sel_cmp_hi) begin
            r_mtimecmp[63:32] <= wdata;
        end
    end

    // Software interrupt bit; it changes only through MSIP writes.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_msip <= 1'b0;
        end else if (w_wr && w_sel_msip) begin
            r_msip <= wdata[0];
        end
    end

    // Timer pending is a registered level compare, so it lags mtime/mtimecmp by one cycle.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_mtip <= 1'b0;
        end else begin
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

`ifdef CLINT_EXT_SYNC_EN
    logic r_ext_meta;
    logic r_ext_sync;

    // Two-flop synchronizer for an external line that may be asynchronous to clk_in.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_ext_meta <= 1'b0;
            r_ext_sync <= 1'b0;
        end else begin
            r_ext_meta <= ext_irq_in;
            r_ext_sync <= r_ext_meta;
        end
    end

    assign meip = r_ext_sync;
`else
    logic r_ext;

    // Single register stage for an external line that is already synchronous to clk_in.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_ext <= 1'b0;
        end else begin
            r_ext <= ext_irq_in;
        end
    end

    assign meip = r_ext;
`endif

    assign ack   = (r_state == ST_ACK);
    assign rdata = r_rdata;
    assign msip  = r_msip;
    assign mtip  = r_mtip;

endmodule

// File: tb/tb_clint_irq.sv
// Testbench for clint_irq. It runs two instances side by side (TICK_DIV=1 and
// TICK_DIV=4) on a shared bus. Expected values come from a time-based model:
// mtime = value at the last anchor + elapsed edges / TICK_DIV.
module tb_clint_irq;

    localparam logic [15:0] A_MSIP  = 16'h0000;
    localparam logic [15:0] A_CMPLO = 16'h4000;
    localparam logic [15:0] A_CMPHI = 16'h4004;
    localparam logic [15:0] A_MTLO  = 16'hBFF8;
    localparam logic [15:0] A_MTHI  = 16'hBFFC;
`ifdef CLINT_EXT_SYNC_EN
    localparam int EXT_LAT = 2;
`else
    localparam int EXT_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic        ext_irq_in = 1'b0;

    logic        ack_o  [2];
    logic [31:0] rdata_o[2];
    logic        msip_o [2];
    logic        mtip_o [2];
    logic        meip_o [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state
    int          m_div[2] = '{1, 4};
    logic [63:0] m_base[2];
    int          m_anchor[2];
    logic [31:0] m_shadow[2];
    logic [63:0] cmp_m;
    logic        msip_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clint_irq #(.TICK_DIV(1), .ADDR_W(16)) u_d1 (
        .clk_in(clk), .reset_in(reset_in), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack_o[0]), .rdata(rdata_o[0]), .ext_irq_in(ext_irq_in),
        .msip(msip_o[0]), .mtip(mtip_o[0]), .meip(meip_o[0])
    );

    clint_irq #(.TICK_DIV(4), .ADDR_W(16)) u_d4 (
        .clk_in(clk), .reset_in(reset_in), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack_o[1]), .rdata(rdata_o[1]), .ext_irq_in(ext_irq_in),
        .msip(msip_o[1]), .mtip(mtip_o[1]), .meip(meip_o[1])
    );

    // mtime value after posedge number k
    function automatic logic [63:0] mt(input int i, input int k);
        int diff;
        diff = k - m_anchor[i];
        if (diff < 0) diff = 0;
        return m_base[i] + 64'(diff / m_div[i]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        msip_m = 1'b0;
        cmp_m  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            m_base[i]   = 64'd0;
            m_anchor[i] = cyc;
            m_shadow[i] = 32'd0;
        end
    endtask

    // One bus transfer, started at a negedge. It returns at the negedge of the idle cycle after ack.
    task automatic bus(input bit w, input logic [15:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd[2];
        logic [15:0] wa;
        logic [63:0] cur;
        int e;
        wa = {a[15:2], 2'b00};
        e  = cyc + 1;
        req = 1'b1; we = w; addr = a; wdata = wd;
        for (int i = 0; i < 2; i++) begin
            exp_rd[i] = 32'd0;
            cur = mt(i, e - 1);
            if (w) begin
                if (wa == A_MTLO || wa == A_MTHI) begin
                    if (wa == A_MTLO) cur[31:0] = wd; else cur[63:32] = wd;
                    m_base[i]   = cur;
                    m_anchor[i] = e;
                end
            end else begin
                case (wa)
                    A_MSIP:  exp_rd[i] = {31'd0, msip_m};
                    A_CMPLO: exp_rd[i] = cmp_m[31:0];
                    A_CMPHI: exp_rd[i] = cmp_m[63:32];
                    A_MTLO: begin
                        exp_rd[i]   = cur[31:0];
                        m_shadow[i] = cur[63:32];
                    end
                    A_MTHI:  exp_rd[i] = m_shadow[i];
                    default: exp_rd[i] = 32'd0;
                endcase
            end
        end
        if (w) begin
            if (wa == A_MSIP)  msip_m = wd[0];
            if (wa == A_CMPLO) cmp_m[31:0] = wd;
            if (wa == A_CMPHI) cmp_m[63:32] = wd;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s d%0d ack", tag, i), 64'(ack_o[i]), 64'd1);
            chk($sformatf("%s d%0d rdata", tag, i), 64'(rdata_o[i]), 64'(exp_rd[i]));
        end
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s d%0d ack_low", tag, i), 64'(ack_o[i]), 64'd0);
            chk($sformatf("%s d%0d rdata_idle", tag, i), 64'(rdata_o[i]), 64'd0);
            chk($sformatf("%s d%0d msip", tag, i), 64'(msip_o[i]), 64'(msip_m));
            chk($sformatf("%s d%0d mtip", tag, i), 64'(mtip_o[i]),
                64'(mt(i, cyc - 1) >= cmp_m));
        end
        $display("txn %s we=%0d addr=%04h wdata=%08h rd0=%08h rd1=%08h t=%0t",
                 tag, w, a, wd, exp_rd[0], exp_rd[1], $time);
    endtask

    initial begin
        bit          hist[16];
        logic [15:0] a;
        int          n;
        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst d%0d ack", i), 64'(ack_o[i]), 64'd0);
            chk($sformatf("rst d%0d rdata", i), 64'(rdata_o[i]), 64'd0);
            chk($sformatf("rst d%0d msip", i), 64'(msip_o[i]), 64'd0);
            chk($sformatf("rst d%0d mtip", i), 64'(mtip_o[i]), 64'd0);
            chk($sformatf("rst d%0d meip", i), 64'(meip_o[i]), 64'd0);
        end
        reset_in = 1'b0;
        model_reset();

        bus(0, A_CMPHI, 32'd0, "rd_cmphi");
        bus(0, A_CMPLO, 32'd0, "rd_cmplo");
        bus(0, A_MTLO,  32'd0, "rd_mtlo");
        bus(0, A_MTHI,  32'd0, "rd_mthi");

        // Software interrupt
        bus(1, A_MSIP, 32'd1, "wr_msip1");
        bus(0, A_MSIP, 32'd0, "rd_msip1");
        bus(1, A_MSIP, 32'd0, "wr_msip0");
        bus(0, A_MSIP, 32'd0, "rd_msip0");

        // Timer interrupt: compare at 100, watch mtip rise on the TICK_DIV=1 instance
        bus(1, A_CMPHI, 32'd0, "wr_cmphi0");
        bus(1, A_CMPLO, 32'd100, "wr_cmplo100");
        n = 0;
        while (mt(0, cyc) <= 64'd105 && n < 300) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 2; i++)
                chk($sformatf("timer d%0d mtip", i), 64'(mtip_o[i]), 64'(mt(i, cyc - 1) >= cmp_m));
        end
        chk("timer d0 reached", 64'(mt(0, cyc) > 64'd105), 64'd1);
        chk("timer d0 mtip_high", 64'(mtip_o[0]), 64'd1);
        bus(1, A_CMPLO, 32'hFFFF_FFFF, "wr_cmplo_max");
        chk("timer d0 mtip_cleared", 64'(mtip_o[0]), 64'd0);

        // Prescaler / mtime write without carry into hi
        bus(1, A_MTHI, 32'd0, "wr_mthi0");
        bus(1, A_MTLO, 32'hFFFF_FFFE, "wr_mtlo_fffe");
        repeat (8) @(negedge clk);
        bus(0, A_MTLO, 32'd0, "rd_mtlo_ps");
        bus(0, A_MTHI, 32'd0, "rd_mthi_ps");

        // Counter carry
        bus(1, A_MTHI, 32'd0, "wr_mthi_c");
        bus(1, A_MTLO, 32'hFFFF_FFFF, "wr_mtlo_c");
        bus(0, A_MTLO, 32'd0, "rd_mtlo_c");
        bus(0, A_MTHI, 32'd0, "rd_mthi_c");

        // External interrupt: 5-cycle pulse
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk($sformatf("ext d%0d meip[%0d]", d, i), 64'(meip_o[d]),
                    64'((i >= EXT_LAT) ? hist[i - EXT_LAT] : 1'b0));
            hist[i] = (i >= 2 && i < 7);
            ext_irq_in = hist[i];
        end

        // Unmapped read
        bus(0, 16'h1234, 32'd0, "rd_unmapped");
        bus(1, 16'h1234, 32'hDEAD_BEEF, "wr_unmapped");

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 6))
                0: a = A_MSIP;
                1: a = A_CMPLO;
                2: a = A_CMPHI;
                3: a = A_MTLO;
                4: a = A_MTHI;
                5: a = 16'h8000;
                default: a = 16'h0004;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            bus(1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset while ack is high
        bus(1, A_MSIP, 32'd1, "wr_msip_pre");
        req = 1'b1; we = 1'b0; addr = A_CMPHI;
        @(negedge clk);
        chk("rstack d0 ack_before", 64'(ack_o[0]), 64'd1);
        reset_in = 1'b1;
        #1;
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rstack d%0d ack", i), 64'(ack_o[i]), 64'd0);
            chk($sformatf("rstack d%0d rdata", i), 64'(rdata_o[i]), 64'd0);
            chk($sformatf("rstack d%0d msip", i), 64'(msip_o[i]), 64'd0);
            chk($sformatf("rstack d%0d mtip", i), 64'(mtip_o[i]), 64'd0);
        end
        @(negedge clk);
        reset_in = 1'b0;
        model_reset();

        // A write whose ack edge is pre-empted by reset is dropped
        req = 1'b1; we = 1'b1; addr = A_MSIP; wdata = 32'd1;
        #2 reset_in = 1'b1;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        for (int i = 0; i < 2; i++)
            chk($sformatf("drop d%0d ack", i), 64'(ack_o[i]), 64'd0);
        reset_in = 1'b0;
        model_reset();
        bus(0, A_MSIP,  32'd0, "post_msip");
        bus(0, A_CMPHI, 32'd0, "post_cmphi");
        bus(0, A_CMPLO, 32'd0, "post_cmplo");
        bus(0, A_MTLO,  32'd0, "post_mtlo");
        bus(0, A_MTHI,  32'd0, "post_mthi");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
